sbox2_inverse_table: RTL and testbench

//   Decoder-side counterpart of the SBOX_2 lookup. After reset, sweeps all 256 SBOX_2 inputs

---
 rtl/sbox2_inverse_table_pkg.sv | 36 +++
 rtl/SBOX_2.sv | 26 ++
 rtl/sbox_inv_mem.sv | 29 ++
 rtl/sbox2_inverse_table.sv | 89 ++++++++
 tb/tb_sbox2_inverse_table.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/sbox2_inverse_table_pkg.sv
// sbox2_inverse_table_pkg: state encoding, table sizes and the Camellia SBOX_2 byte function
// Shared by the ROM model, the inverse-table memory and the sweep/lookup top.
package sbox2_inverse_table_pkg;
    typedef enum logic [1:0] {
        SWEEP = 2'd0,
        DRAIN = 2'd1,
        READY = 2'd2,
        ERROR = 2'd3
    } state_t;
    localparam int SBOX_DEPTH = 256;
    localparam int SBOX_W = 8;
    localparam int SBOX1 [256] = '{
        112, 130,  44, 236, 179,  39, 192, 229, 228, 133,  87,  53, 234,  12, 174,  65,
         35, 239, 107, 147,  69,  25, 165,  33, 237,  14,  79,  78,  29, 101, 146, 189,
        134, 184, 175, 143, 124, 235,  31, 206,  62,  48, 220,  95,  94, 197,  11,  26,
        166, 225,  57, 202, 213,  71,  93,  61, 217,   1,  90, 214,  81,  86, 108,  77,
        139,  13, 154, 102, 251, 204, 176,  45, 116,  18,  43,  32, 240, 177, 132, 153,
        223,  76, 203, 194,  52, 126, 118,   5, 109, 183, 169,  49, 209,  23,   4, 215,
         20,  88,  58,  97, 222,  27,  17,  28,  50,  15, 156,  22,  83,  24, 242,  34,
        254,  68, 207, 178, 195, 181, 122, 145,  36,   8, 232, 168,  96, 252, 105,  80,
        170, 208, 160, 125, 161, 137,  98, 151,  84,  91,  30, 149, 224, 255, 100, 210,
         16, 196,   0,  72, 163, 247, 117, 219, 138,   3, 230, 218,   9,  63, 221, 148,
        135,  92, 131,   2, 205,  74, 144,  51, 115, 103, 246, 243, 157, 127, 191, 226,
         82, 155, 216,  38, 200,  55, 198,  59, 129, 150, 111,  75,  19, 190,  99,  46,
        233, 121, 167, 140, 159, 110, 188, 142,  41, 245, 249, 182,  47, 253, 180,  89,
        120, 152,   6, 106, 231,  70, 113, 186, 212,  37, 171,  66, 136, 162, 141, 250,
        114,   7, 185,  85, 248, 238, 172,  10,  54,  73,  42, 104,  60,  56, 241, 164,
         64,  40, 211, 123, 187, 201,  67, 193,  21, 227, 173, 244, 119, 199, 128, 158
    };
    // SBOX_2 is SBOX_1 rotated left by one bit
    function automatic logic [SBOX_W-1:0] sbox2(input logic [SBOX_W-1:0] x);
        logic [SBOX_W-1:0] s;
        s = SBOX_W'(SBOX1[x]);
        return {s[SBOX_W-2:0], s[SBOX_W-1]};
    endfunction
endpackage

// File: rtl/SBOX_2.sv
// SBOX_2: dual-port SBOX_2 ROM with ROM_LAT cycles of read latency
// Ports: clk; addra_s2/addrb_s2 read addresses; douta_s2/doutb_s2 data, valid ROM_LAT cycles later.
module SBOX_2
    import sbox2_inverse_table_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic [SBOX_W-1:0] addra_s2,
    input  logic [SBOX_W-1:0] addrb_s2,
    output logic [SBOX_W-1:0] douta_s2,
    output logic [SBOX_W-1:0] doutb_s2
);
    logic [SBOX_W-1:0] qa [ROM_LAT];
    logic [SBOX_W-1:0] qb [ROM_LAT];
    always_ff @(posedge clk) begin
        qa[0] <= sbox2(addra_s2);
        qb[0] <= sbox2(addrb_s2);
        for (int i = 1; i < ROM_LAT; i++) begin
            qa[i] <= qa[i-1];
            qb[i] <= qb[i-1];
        end
    end
    assign douta_s2 = qa[ROM_LAT-1];
    assign doutb_s2 = qb[ROM_LAT-1];
endmodule

// File: rtl/sbox_inv_mem.sv
// sbox_inv_mem: 256x8 register file, two write ports sharing one enable, one registered read port
// Ports: clk, rst (async, clears only the read register); we, wa_*/wb_* writes (B wins on a
// same-address collision); re, raddr read request; rdata holds its value when re is low.
module sbox_inv_mem
    import sbox2_inverse_table_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [SBOX_W-1:0] wa_addr,
    input  logic [SBOX_W-1:0] wa_data,
    input  logic [SBOX_W-1:0] wb_addr,
    input  logic [SBOX_W-1:0] wb_data,
    input  logic              re,
    input  logic [SBOX_W-1:0] raddr,
    output logic [SBOX_W-1:0] rdata
);
    logic [SBOX_W-1:0] mem [SBOX_DEPTH];
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa_addr] <= wa_data;
            mem[wb_addr] <= wb_data;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sbox2_inverse_table.sv
// sbox2_inverse_table: builds and verifies the SBOX_2 inverse table after reset, then serves lookups
// Ports: clk, rst (async, active high); init_done/init_err report the sweep outcome;
// req_valid/req_ready/req_data carry an inverse request; resp_valid/resp_data return x with SBOX_2(x)=req_data.
module sbox2_inverse_table
    import sbox2_inverse_table_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    output logic              init_err,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SBOX_W-1:0] req_data,
    output logic              resp_valid,
    output logic [SBOX_W-1:0] resp_data
);
    state_t state;
    logic [6:0] k;
    logic [SBOX_DEPTH-1:0] seen;
    logic err_pend;
    logic [ROM_LAT-1:0] pv;
    logic [6:0] pk [ROM_LAT];
    logic [SBOX_W-1:0] addra_s2, addrb_s2, douta_s2, doutb_s2;
    logic wr, dup, drained, bad;
    assign addra_s2 = {k, 1'b0};
    assign addrb_s2 = {k, 1'b1};
    assign wr = pv[ROM_LAT-1];
    assign dup = wr && (seen[douta_s2] || seen[doutb_s2] || douta_s2 == doutb_s2);
    // only the output stage may still be valid: this edge writes the final pair
    assign drained = state == DRAIN && (pv << 1) == '0;
    assign bad = err_pend || dup;
    SBOX_2 #(.ROM_LAT(ROM_LAT)) u_rom (
        .clk(clk),
        .addra_s2(addra_s2),
        .addrb_s2(addrb_s2),
        .douta_s2(douta_s2),
        .doutb_s2(doutb_s2)
    );
    sbox_inv_mem u_mem (
        .clk(clk),
        .rst(rst),
        .we(wr),
        .wa_addr(douta_s2),
        .wa_data({pk[ROM_LAT-1], 1'b0}),
        .wb_addr(doutb_s2),
        .wb_data({pk[ROM_LAT-1], 1'b1}),
        .re(req_valid && req_ready),
        .raddr(req_data),
        .rdata(resp_data)
    );
    // pair index travels alongside the ROM latency; validity lives in pv
    always_ff @(posedge clk) begin
        pk[0] <= k;
        for (int i = 1; i < ROM_LAT; i++) pk[i] <= pk[i-1];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SWEEP;
            k <= '0;
            seen <= '0;
            err_pend <= 1'b0;
            pv <= '0;
            init_done <= 1'b0;
            init_err <= 1'b0;
            req_ready <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            pv <= ROM_LAT'({pv, state == SWEEP});
            resp_valid <= req_valid && req_ready;
            if (wr) begin
                seen[douta_s2] <= 1'b1;
                seen[doutb_s2] <= 1'b1;
            end
            if (dup) err_pend <= 1'b1;
            if (state == SWEEP) begin
                k <= k + 7'd1;
                if (k == 7'd127) state <= DRAIN;
            end
            if (drained) begin
                state <= bad ? ERROR : READY;
                init_done <= !bad;
                init_err <= bad;
                req_ready <= !bad;
            end
        end
    end
endmodule

// File: tb/tb_sbox2_inverse_table.sv
// tb_sbox2_inverse_table: checks sweep timing, inverse lookups and error detection for ROM_LAT 1..3
module tb_sbox2_inverse_table;
    localparam int SB1 [256] = '{
        112, 130,  44, 236, 179,  39, 192, 229, 228, 133,  87,  53, 234,  12, 174,  65,
         35, 239, 107, 147,  69,  25, 165,  33, 237,  14,  79,  78,  29, 101, 146, 189,
        134, 184, 175, 143, 124, 235,  31, 206,  62,  48, 220,  95,  94, 197,  11,  26,
        166, 225,  57, 202, 213,  71,  93,  61, 217,   1,  90, 214,  81,  86, 108,  77,
        139,  13, 154, 102, 251, 204, 176,  45, 116,  18,  43,  32, 240, 177, 132, 153,
        223,  76, 203, 194,  52, 126, 118,   5, 109, 183, 169,  49, 209,  23,   4, 215,
         20,  88,  58,  97, 222,  27,  17,  28,  50,  15, 156,  22,  83,  24, 242,  34,
        254,  68, 207, 178, 195, 181, 122, 145,  36,   8, 232, 168,  96, 252, 105,  80,
        170, 208, 160, 125, 161, 137,  98, 151,  84,  91,  30, 149, 224, 255, 100, 210,
         16, 196,   0,  72, 163, 247, 117, 219, 138,   3, 230, 218,   9,  63, 221, 148,
        135,  92, 131,   2, 205,  74, 144,  51, 115, 103, 246, 243, 157, 127, 191, 226,
         82, 155, 216,  38, 200,  55, 198,  59, 129, 150, 111,  75,  19, 190,  99,  46,
        233, 121, 167, 140, 159, 110, 188, 142,  41, 245, 249, 182,  47, 253, 180,  89,
        120, 152,   6, 106, 231,  70, 113, 186, 212,  37, 171,  66, 136, 162, 141, 250,
        114,   7, 185,  85, 248, 238, 172,  10,  54,  73,  42, 104,  60,  56, 241, 164,
         64,  40, 211, 123, 187, 201,  67, 193,  21, 227, 173, 244, 119, 199, 128, 158
    };
    typedef struct {
        logic [7:0] req;
        logic [7:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] req_valid = '0;
    logic [7:0] req_data = '0;
    logic [2:0] done, err, rdy, rv;
    logic [7:0] rd [3];
    logic [7:0] dupv;
    int total = 0;
    int bad = 0;
    int inv_m [256];
    vec_t vt [5];
    always #5 clk = ~clk;
    sbox2_inverse_table #(.ROM_LAT(1)) dut1 (.clk(clk), .rst(rst), .init_done(done[0]), .init_err(err[0]),
        .req_valid(req_valid[0]), .req_ready(rdy[0]), .req_data(req_data), .resp_valid(rv[0]), .resp_data(rd[0]));
    sbox2_inverse_table #(.ROM_LAT(2)) dut2 (.clk(clk), .rst(rst), .init_done(done[1]), .init_err(err[1]),
        .req_valid(req_valid[1]), .req_ready(rdy[1]), .req_data(req_data), .resp_valid(rv[1]), .resp_data(rd[1]));
    sbox2_inverse_table #(.ROM_LAT(3)) dut3 (.clk(clk), .rst(rst), .init_done(done[2]), .init_err(err[2]),
        .req_valid(req_valid[2]), .req_ready(rdy[2]), .req_data(req_data), .resp_valid(rv[2]), .resp_data(rd[2]));
    function automatic int sb2(input int x);
        int s;
        s = SB1[x & 255];
        return ((s << 1) | (s >> 7)) & 255;
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        repeat (3) tick;
        for (int d = 0; d < 3; d++) chk("reset_state", {done[d], err[d], rdy[d], rv[d], rd[d]}, 0);
        rst = 1'b0;
    endtask
    task automatic wait_init(input int d, output int n);
        n = 0;
        do begin
            tick;
            n++;
        end while (!(done[d] || err[d]) && n < 400);
    endtask
    task automatic run_basic(input int d);
        int n, pulses;
        int perm [256];
        do_reset;
        wait_init(d, n);
        chk("init_cycle", n, 129 + d);
        chk("init_err", err[d], 0);
        chk("ready_with_done", rdy[d], 1);
        for (int i = 0; i < 5; i++) begin
            req_valid[d] = 1'b1;
            req_data = vt[i].req;
            tick;
            req_valid[d] = 1'b0;
            chk("vec_valid", rv[d], 1);
            chk("vec_data", rd[d], vt[i].exp);
            tick;
            chk("vec_idle", rv[d], 0);
            chk("vec_hold", rd[d], vt[i].exp);
        end
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            req_valid[d] = 1'b1;
            req_data = 8'(perm[i]);
            tick;
            if (rv[d]) pulses++;
            chk("b2b_fwd", sb2(rd[d]), perm[i]);
            chk("b2b_inv", rd[d], inv_m[perm[i]]);
        end
        req_valid[d] = 1'b0;
        tick;
        chk("b2b_end_idle", rv[d], 0);
        chk("b2b_pulses", pulses, 256);
    endtask
    initial begin
        int n, pre;
        for (int x = 0; x < 256; x++) inv_m[sb2(x)] = x;
        vt[0] = '{8'hE0, 8'h00};
        vt[1] = '{8'h05, 8'h01};
        vt[2] = '{8'h58, 8'h02};
        vt[3] = '{8'h3D, 8'hFF};
        n = int'($urandom_range(255, 0));
        vt[4] = '{8'(sb2(n)), 8'(n)};
        run_basic(0);
        do_reset;
        req_valid[0] = 1'b1;
        req_data = 8'hE0;
        pre = 0;
        n = 0;
        do begin
            tick;
            n++;
            if (rv[0]) pre++;
        end while (!rdy[0] && n < 400);
        chk("sweep_no_resp", pre, 0);
        chk("rdy_cycle", n, 129);
        tick;
        req_valid[0] = 1'b0;
        chk("first_resp_valid", rv[0], 1);
        chk("first_resp_data", rd[0], 0);
        do_reset;
        repeat (60) tick;
        rst = 1'b1;
        #1;
        chk("midsweep_reset", {done[0], err[0], rdy[0], rv[0], rd[0]}, 0);
        tick;
        tick;
        rst = 1'b0;
        wait_init(0, n);
        chk("restart_cycle", n, 129);
        chk("restart_done", done[0], 1);
        do_reset;
        dupv = 8'(sb2(8'h10));
        n = 0;
        do begin
            tick;
            n++;
            if (n == 17) force dut1.douta_s2 = dupv;
            if (n == 18) release dut1.douta_s2;
        end while (!(done[0] || err[0]) && n < 400);
        chk("dup_err_cycle", n, 129);
        chk("dup_err", err[0], 1);
        chk("dup_done", done[0], 0);
        chk("dup_ready", rdy[0], 0);
        req_valid[0] = 1'b1;
        pre = 0;
        repeat (10) begin
            tick;
            if (rv[0] || rdy[0]) pre++;
        end
        req_valid[0] = 1'b0;
        chk("error_no_resp", pre, 0);
        run_basic(1);
        run_basic(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
